exec_datapath: RTL
==================

# exec_datapath

Parametrised, self-sequencing successor to the single-bus CPU datapath. It holds a WIDTH-bit, NREGS-entry register file plus the Y, Z, HI and LO registers on one internal bus. It accepts one register-to-register operation per valid/ready handshake and steps it through fixed micro-cycles (operand to Y, ALU to Z, Z to destination) without external control strobes. It sits between the future control unit and the memory/IO path.

## Interface
Parameters:
- WIDTH, 32, datapath and register width
- NREGS, 16, register count; power of two, 2 to 64
- AW, $clog2(NREGS), register-address width (derived, not overridden)

Ports:
- clock  in  1  sole clock, rising edge
- clear  in  1  asynchronous, active-low reset
- req_valid  in  1  operation request
- req_ready  out  1  high when idle; a request is accepted on an edge where req_valid && req_ready
- req_op  in  5  opcode
- req_ra, req_rb, req_rc  in  AW  destination, source B, source C
- req_imm  in  WIDTH  immediate for LDI
- done  out  1  one-cycle completion pulse
- err  out  1  sticky illegal-opcode flag; cleared only by clear
- bus_out  out  WIDTH  current internal bus value (observation)
- dbg_addr  in  AW  debug read address
- dbg_data  out  WIDTH  combinational read of register dbg_addr
- hi_q, lo_q  out  WIDTH  HI and LO contents

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (Rb−Rc), 2 AND, 3 OR
  - 4 SHL, 5 SHR logical, 6 SHRA; shift amount is Rc[$clog2(WIDTH)-1:0]
  - 7 NEG (−Rb), 8 NOT (~Rb), 9 MUL (signed Rb×Rc, 2·WIDTH product), 10 MOV (Rb), 11 LDI (imm)
  - 12–31 illegal
- States are IDLE, S_Y, S_Z, S_WB and S_WBH.
- IDLE: req_ready=1, bus_out=0. On accept, latch op/ra/rb/rc/imm and go to S_Y.
- S_Y: bus=Rb, Yin. Go to S_Z.
- S_Z: Zin with ALU(Y, bus).
  - bus=Rc for ADD/SUB/AND/OR/shifts/MUL.
  - bus=Rb for NEG/NOT/MOV.
  - bus=imm for LDI.
  - Go to S_WB.
- S_WB: bus=Zlow.
  - MUL: written to LO, then go to S_WBH.
  - Other legal ops: written to Ra, then go to IDLE.
  - Illegal op: no write, err set, go to IDLE.
- S_WBH: bus=Zhigh, written to HI. Go to IDLE.
- done is registered. It is high for exactly the one cycle after the final write edge, during which req_ready is already 1.
- Arithmetic is modulo 2^WIDTH. Only MUL produces the high half.
- R0 always reads 0, and writes to it are discarded. A MOV/LDI/ADD into R0 still completes and pulses done.
- Ra may equal Rb or Rc. Sources are consumed before the write edge.

## Timing
- Reset values: all registers, Y, Z, HI, LO = 0; state IDLE; done=0; err=0; req_ready=1; bus_out=0.
- Latency from the accept edge to the result visible on dbg_data: 3 edges (MUL: LO after 3 edges, HI after 4).
- done is high in cycle 4 after accept (5 for MUL).
- Back-to-back: a request accepted in the done cycle starts its S_Y on the next cycle. Issue rate is 1 op per 4 cycles (MUL 5).
- req_* are ignored when not in IDLE. No queuing.
- clear asserted mid-operation: abort immediately, all state to reset values, no partial write.
- dbg_data reflects a write on the same edge it occurs (registered value, combinational mux).

## Configuration
- HILO_EN defined: HI and LO registers, a 2·WIDTH Z, MUL legal, and S_WBH present.
- HILO_EN undefined:
  - MUL (9) is illegal: err set, no writes, done at cycle 4.
  - Z is WIDTH bits, and S_WBH does not exist.
  - hi_q and lo_q are tied to 0.

## Structure
- Package exec_pkg holds the opcode enum (5-bit), the state enum and the OP_LAST_LEGAL constant.
- Sub-module exec_alu is the combinational ALU: Y, B, op in; 2·WIDTH result out.
- The register file, bus mux and sequencer live in exec_datapath.

## Test plan
- LDI R1=5, LDI R2=3, ADD R3,R1,R2 → dbg R3=8; done exactly 4 cycles after each accept; req_ready low for cycles 1–3.
- SUB R4,R2,R1 → R4=0xFFFFFFFE; SHRA R5 with R5←0x80000000 by 4 → 0xF8000000; SHR of the same value → 0x08000000.
- MUL with 0x00010000×0x00010000 → HI=1, LO=0, done at cycle 5; MUL −2×3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA. Without HILO_EN: err=1, LO unchanged.
- LDI R0=0x1234, then ADD R6,R0,R0 → R0 and R6 read 0; both ops pulse done.
- Opcode 31 → no register changes, err=1 and stays 1 across later legal ops until clear.
- clear pulsed at S_Z of ADD R7 → R7=0, req_ready=1, done=0; next request completes normally. Repeat with NREGS=32 and WIDTH=16 to check wrap and sign behaviour.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcode/state encodings for the self-sequencing exec datapath.
package exec_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SHL  = 5'd4,
        OP_SHR  = 5'd5,
        OP_SHRA = 5'd6,
        OP_NEG  = 5'd7,
        OP_NOT  = 5'd8,
        OP_MUL  = 5'd9,
        OP_MOV  = 5'd10,
        OP_LDI  = 5'd11
    } op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_Y   = 3'd1,
        S_Z   = 3'd2,
        S_WB  = 3'd3,
        S_WBH = 3'd4
    } state_e;

    localparam logic [4:0] OP_LAST_LEGAL = 5'd11;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: Y is the latched first operand, B is the current bus value.
// Only MUL fills the upper half of the 2*WIDTH result.
module exec_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         op,
    output logic [2*WIDTH-1:0] res
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]            sh;
    logic signed [2*WIDTH-1:0] y_ext;
    logic signed [2*WIDTH-1:0] b_ext;

    assign sh    = b[SHW-1:0];
    assign y_ext = {{WIDTH{y[WIDTH-1]}}, y};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res[WIDTH-1:0] = y + b;
            OP_SUB:  res[WIDTH-1:0] = y - b;
            OP_AND:  res[WIDTH-1:0] = y & b;
            OP_OR:   res[WIDTH-1:0] = y | b;
            OP_SHL:  res[WIDTH-1:0] = y << sh;
            OP_SHR:  res[WIDTH-1:0] = y >> sh;
            OP_SHRA: res[WIDTH-1:0] = $signed(y) >>> sh;
            OP_NEG:  res[WIDTH-1:0] = '0 - b;
            OP_NOT:  res[WIDTH-1:0] = ~b;
            // Both operands sign-extended so the low 2*WIDTH bits are the signed product
            OP_MUL:  res = y_ext * b_ext;
            OP_MOV:  res[WIDTH-1:0] = b;
            OP_LDI:  res[WIDTH-1:0] = b;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/exec_datapath.sv
// Single-bus datapath with register file, Y/Z/HI/LO and a built-in micro-cycle sequencer.
// Optional macro HILO_EN adds HI/LO, a double-width Z and the MUL high-half write-back.
module exec_datapath
    import exec_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [AW-1:0]    req_ra,
    input  logic [AW-1:0]    req_rb,
    input  logic [AW-1:0]    req_rc,
    input  logic [WIDTH-1:0] req_imm,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] bus_out,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

`ifdef HILO_EN
    localparam int   ZW   = 2 * WIDTH;
    localparam logic HILO = 1'b1;
`else
    localparam int   ZW   = WIDTH;
    localparam logic HILO = 1'b0;
`endif

    state_e                      state_q, state_d;
    logic [4:0]                  op_q, op_d;
    logic [AW-1:0]               ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic [WIDTH-1:0]            imm_q, imm_d;
    logic [WIDTH-1:0]            y_q, y_d;
    logic [ZW-1:0]               z_q, z_d;
    logic [NREGS-1:0][WIDTH-1:0] rf_q, rf_d;
    logic                        done_q, done_d;
    logic                        err_q, err_d;

    logic [WIDTH-1:0]            bus;
    logic [2*WIDTH-1:0]          alu_res;
    logic                        op_mul;
    logic                        op_legal;

    assign op_mul   = (op_q == OP_MUL);
    assign op_legal = (op_q <= OP_LAST_LEGAL) && (HILO || !op_mul);

    // Internal bus source per micro-cycle
    always_comb begin
        bus = '0;
        case (state_q)
            S_Y: bus = rf_q[rb_q];
            S_Z: begin
                case (op_q)
                    OP_NEG, OP_NOT, OP_MOV: bus = rf_q[rb_q];
                    OP_LDI:                 bus = imm_q;
                    default:                bus = rf_q[rc_q];
                endcase
            end
            S_WB: bus = z_q[WIDTH-1:0];
`ifdef HILO_EN
            S_WBH: bus = z_q[2*WIDTH-1:WIDTH];
`endif
            default: bus = '0;
        endcase
    end

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .y   (y_q),
        .b   (bus),
        .op  (op_q),
        .res (alu_res)
    );

`ifdef HILO_EN
    logic [WIDTH-1:0] hi_d, lo_d;
`else
    logic unused_alu_hi;
    assign unused_alu_hi = ^alu_res[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        imm_d   = imm_q;
        y_d     = y_q;
        z_d     = z_q;
        rf_d    = rf_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef HILO_EN
        hi_d    = hi_q;
        lo_d    = lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    ra_d    = req_ra;
                    rb_d    = req_rb;
                    rc_d    = req_rc;
                    imm_d   = req_imm;
                    state_d = S_Y;
                end
            end
            S_Y: begin
                y_d     = bus;
                state_d = S_Z;
            end
            S_Z: begin
                z_d     = alu_res[ZW-1:0];
                state_d = S_WB;
            end
            S_WB: begin
                if (!op_legal) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`ifdef HILO_EN
                else if (op_mul) begin
                    lo_d    = bus;
                    state_d = S_WBH;
                end
`endif
                else begin
                    // R0 is hardwired to zero; the op still completes
                    if (ra_q != '0) rf_d[ra_q] = bus;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            S_WBH: begin
`ifdef HILO_EN
                hi_d    = bus;
`endif
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            imm_q   <= '0;
            y_q     <= '0;
            z_q     <= '0;
            rf_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            imm_q   <= imm_d;
            y_q     <= y_d;
            z_q     <= z_d;
            rf_q    <= rf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef HILO_EN
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
`else
    assign hi_q = '0;
    assign lo_q = '0;
`endif

    assign req_ready = (state_q == IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign bus_out   = bus;
    assign dbg_data  = rf_q[dbg_addr];

endmodule
